// File: rtl/oc_retry_controller_pkg.sv
// Shared types and sizing helpers for the overcurrent retry controller.
// State encoding is fixed so that debug probes read consistent values.
package oc_retry_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_COOLDOWN = 3'd2,
    S_CLEAR_OC = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  function automatic int retryWidth(input int maxRetries);
    return $clog2(maxRetries + 1);
  endfunction

  // Width of the shared down-counter, large enough for the longer of the two waits.
  function automatic int timerWidth(input logic [31:0] cool, input logic [31:0] pulse);
    logic [32:0] m;
    m = (cool > pulse) ? {1'b0, cool} : {1'b0, pulse};
    return $clog2(m + 33'd1);
  endfunction

endpackage

// File: rtl/oc_retry_controller_if.sv
// Command/detector bundle between operator logic, the controller and the H-bridge side.
interface oc_retry_controller_if
  import oc_retry_controller_pkg::*;
#(
  parameter int MAX_RETRIES = 3
) ();
  localparam int RW = retryWidth(MAX_RETRIES);

  logic          run_req;
  logic          oc_in;
  logic          clear;
  logic          motor_en;
  logic          oc_reset;
  logic          fault;
  logic [RW-1:0] retry_count;

  modport master (
    output run_req, oc_in, clear,
    input  motor_en, oc_reset, fault, retry_count
  );

  modport slave (
    input  run_req, oc_in, clear,
    output motor_en, oc_reset, fault, retry_count
  );
endinterface

// File: rtl/oc_ctrl_timer.sv
// Loadable down-counter shared by the cooldown wait and the detector reset pulse.
module oc_ctrl_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  output logic             o_done
);
  logic [WIDTH-1:0] r_count;

  // Parks at zero so a stale count can never wrap while unused.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);
endmodule

// File: rtl/oc_retry_controller.sv
// Supervisory sequencer: gates motor drive, retries after overcurrent trips,
// and latches a lockout after too many consecutive trips.
module oc_retry_controller
  import oc_retry_controller_pkg::*;
#(
  parameter logic [31:0] COOLDOWN    = 32'd1000000,
  parameter int          MAX_RETRIES = 3,
  parameter int          RST_PULSE   = 2,
  parameter logic [31:0] GOOD_TIME   = 32'd5000000
) (
  input logic                  clk,
  input logic                  reset,
  oc_retry_controller_if.slave bus
);
  localparam int RW = retryWidth(MAX_RETRIES);
  localparam int TW = timerWidth(COOLDOWN, 32'(RST_PULSE));

  // The timer counts down to zero inclusive, so load one less than the dwell.
  localparam logic [TW-1:0] COOL_LOAD  = TW'(COOLDOWN - 32'd1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(RST_PULSE - 1);
  localparam logic [RW-1:0] LAST_RETRY = RW'(MAX_RETRIES - 1);
  localparam logic [31:0]   GOOD_LAST  = GOOD_TIME - 32'd1;

  state_t        r_state;
  logic          r_motorEn;
  logic          r_ocReset;
  logic          r_fault;
  logic [RW-1:0] r_retry;
  logic [31:0]   r_good;

  logic          w_timerDone;
  logic          w_lastTrip;
  logic          w_trip;
  logic          w_toCool;
  logic          w_toClear;
  logic          w_load;
  logic [TW-1:0] w_loadVal;

  assign w_lastTrip = (r_retry == LAST_RETRY);
  assign w_trip     = (r_state == S_RUN) && bus.oc_in;
  assign w_toCool   = w_trip && !w_lastTrip;
  assign w_toClear  = ((r_state == S_IDLE) && bus.oc_in)
                   || ((r_state == S_COOLDOWN) && w_timerDone)
                   || ((r_state == S_LOCKOUT) && bus.clear && !bus.run_req);
  assign w_load     = w_toCool || w_toClear;
  assign w_loadVal  = w_toCool ? COOL_LOAD : PULSE_LOAD;

  oc_ctrl_timer #(.WIDTH(TW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_loadVal (w_loadVal),
    .o_done    (w_timerDone)
  );

  // Outputs are written alongside each transition so they always reflect the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_motorEn <= 1'b0;
      r_ocReset <= 1'b0;
      r_fault   <= 1'b0;
      r_retry   <= '0;
      r_good    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_toClear) begin
            r_state   <= S_CLEAR_OC;
            r_ocReset <= 1'b1;
          end else if (bus.run_req) begin
            r_state   <= S_RUN;
            r_motorEn <= 1'b1;
            r_good    <= '0;
          end
        end
        S_RUN: begin
          if (w_trip) begin
            r_retry   <= r_retry + 1'b1;
            r_motorEn <= 1'b0;
            r_good    <= '0;
            if (w_lastTrip) begin
              r_state <= S_LOCKOUT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_COOLDOWN;
            end
          end else if (!bus.run_req) begin
            r_state   <= S_IDLE;
            r_motorEn <= 1'b0;
            r_good    <= '0;
          end else if (r_good == GOOD_LAST) begin
            r_retry <= '0;
            r_good  <= '0;
          end else begin
            r_good <= r_good + 32'd1;
          end
        end
        S_COOLDOWN: begin
          if (w_toClear) begin
            r_state   <= S_CLEAR_OC;
            r_ocReset <= 1'b1;
          end
        end
        S_CLEAR_OC: begin
          if (w_timerDone) begin
            r_ocReset <= 1'b0;
            if (bus.run_req) begin
              r_state   <= S_RUN;
              r_motorEn <= 1'b1;
              r_good    <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_LOCKOUT: begin
          // Clear is honoured only with run dropped, so releasing cannot restart the motor.
          if (w_toClear) begin
            r_state   <= S_CLEAR_OC;
            r_ocReset <= 1'b1;
            r_fault   <= 1'b0;
            r_retry   <= '0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_motorEn <= 1'b0;
          r_ocReset <= 1'b0;
          r_fault   <= 1'b0;
          r_retry   <= '0;
          r_good    <= '0;
        end
      endcase
    end
  end

  assign bus.motor_en    = r_motorEn;
  assign bus.oc_reset    = r_ocReset;
  assign bus.fault       = r_fault;
  assign bus.retry_count = r_retry;
endmodule
